// File: rtl/rasterizador_pkg.sv
// Shared types and width helpers for the triangle rasterizer.
//   acc_w(cw) : width of an edge-function value for cw-bit coordinates
//   cnt_w(cw) : width of the emitted-point counter (covers a full 2^cw x 2^cw box)
//   estado_t  : scan controller states
package rasterizador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCAN,
    ST_FLUSH,
    ST_DONE
  } estado_t;

  function automatic int acc_w(input int cw);
    return 2 * cw + 3;
  endfunction

  function automatic int cnt_w(input int cw);
    return 2 * cw + 1;
  endfunction

endpackage

// File: rtl/rasterizador_triangulo_aresta.sv
// funcao_aresta: combinational edge function
//   e = (tx-bx)*(ay-by) - (ax-bx)*(ty-by)
// Ports: ax,ay,bx,by,tx,ty  unsigned COORD_W-bit coordinates
//        e                  signed acc_w(COORD_W)-bit result (cannot overflow)
module funcao_aresta import rasterizador_pkg::*; #(
  parameter int COORD_W = 12
) (
  input  logic [COORD_W-1:0]                ax,
  input  logic [COORD_W-1:0]                ay,
  input  logic [COORD_W-1:0]                bx,
  input  logic [COORD_W-1:0]                by,
  input  logic [COORD_W-1:0]                tx,
  input  logic [COORD_W-1:0]                ty,
  output logic signed [acc_w(COORD_W)-1:0]  e
);

  localparam int ACC_W = acc_w(COORD_W);
  localparam int PW    = 2 * COORD_W + 2;

  // Differences of zero-extended coordinates fit in COORD_W+1 signed bits.
  logic signed [COORD_W:0] dtx, day, dax, dty;
  logic signed [PW-1:0]    m1, m2;

  always_comb begin
    dtx = $signed({1'b0, tx}) - $signed({1'b0, bx});
    day = $signed({1'b0, ay}) - $signed({1'b0, by});
    dax = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dty = $signed({1'b0, ty}) - $signed({1'b0, by});
    m1  = PW'(dtx) * PW'(day);
    m2  = PW'(dax) * PW'(dty);
    e   = ACC_W'(m1) - ACC_W'(m2);
  end

endmodule

// File: rtl/rasterizador_triangulo.sv
// rasterizador_triangulo: latches three vertices, scans their bounding box
// row-major one candidate per cycle and streams every lattice point inside
// the triangle on a valid/ready interface.
// Ports:
//   clk, rst                 clock / async active-high reset
//   start                    request, honoured only in IDLE
//   p1x..p3y                 vertices, latched on the accepted start
//   busy                     SETUP..FLUSH
//   out_valid/out_ready      output handshake, out_x/out_y the point
//   done                     one-cycle end-of-scan pulse
//   count                    points emitted for the last triangle
module rasterizador_triangulo import rasterizador_pkg::*; #(
  parameter int COORD_W       = 12,
  parameter bit INCL_EDGE     = 1'b1,
  parameter bit BOTH_WINDINGS = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [COORD_W-1:0]           p1x,
  input  logic [COORD_W-1:0]           p1y,
  input  logic [COORD_W-1:0]           p2x,
  input  logic [COORD_W-1:0]           p2y,
  input  logic [COORD_W-1:0]           p3x,
  input  logic [COORD_W-1:0]           p3y,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COORD_W-1:0]           out_x,
  output logic [COORD_W-1:0]           out_y,
  output logic                         done,
  output logic [cnt_w(COORD_W)-1:0]    count
);

  localparam int ACC_W = acc_w(COORD_W);
  localparam int CNT_W = cnt_w(COORD_W);

  estado_t estado, estado_n;

  logic [2:0][COORD_W-1:0] vx, vy;
  logic [COORD_W-1:0]      xmin, xmax, ymax, x, y;
  logic                    neg;          // area < 0: inside means Ei <= 0
  logic [2:0][ACC_W-1:0]   e;
  logic [COORD_W-1:0]      bx_min, bx_max, by_min, by_max;
  logic                    area_neg, area_zero, inside_ok, adv, last;

  // Edge functions E(p1,p2,t), E(p2,p3,t), E(p3,p1,t). Lane 0 doubles as the
  // area evaluator in SETUP by pointing t at p3.
  for (genvar i = 0; i < 3; i++) begin : g_aresta
    localparam int J = (i + 1) % 3;
    logic [COORD_W-1:0] tx, ty;
    if (i == 0) begin : g_mux
      assign tx = (estado == ST_SETUP) ? vx[2] : x;
      assign ty = (estado == ST_SETUP) ? vy[2] : y;
    end else begin : g_scan
      assign tx = x;
      assign ty = y;
    end
    funcao_aresta #(.COORD_W(COORD_W)) u_aresta (
      .ax(vx[i]), .ay(vy[i]), .bx(vx[J]), .by(vy[J]),
      .tx(tx),    .ty(ty),    .e(e[i])
    );
  end

  always_comb begin
    bx_min = vx[0]; bx_max = vx[0];
    by_min = vy[0]; by_max = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < bx_min) bx_min = vx[i];
      if (vx[i] > bx_max) bx_max = vx[i];
      if (vy[i] < by_min) by_min = vy[i];
      if (vy[i] > by_max) by_max = vy[i];
    end
  end

  assign area_neg  = e[0][ACC_W-1];
  assign area_zero = (e[0] == '0);

  // Orientation is applied as a sign compare rather than a negation.
  always_comb begin
    inside_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (INCL_EDGE) begin
        if (!((e[i] == '0) || (e[i][ACC_W-1] == neg))) inside_ok = 1'b0;
      end else begin
        if ((e[i] == '0) || (e[i][ACC_W-1] != neg)) inside_ok = 1'b0;
      end
    end
  end

  assign adv  = !(out_valid && !out_ready);
  assign last = (x == xmax) && (y == ymax);
  assign busy = (estado == ST_SETUP) || (estado == ST_SCAN) || (estado == ST_FLUSH);
  assign done = (estado == ST_DONE);

  always_comb begin
    estado_n = estado;
    case (estado)
      ST_IDLE:  if (start) estado_n = ST_SETUP;
      ST_SETUP: estado_n = (area_zero || (area_neg && !BOTH_WINDINGS)) ? ST_DONE : ST_SCAN;
      ST_SCAN:  if (adv && last) estado_n = ST_FLUSH;
      ST_FLUSH: if (!out_valid || out_ready) estado_n = ST_DONE;
      ST_DONE:  estado_n = ST_IDLE;
      default:  estado_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= ST_IDLE;
    else     estado <= estado_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx        <= '0;
      vy        <= '0;
      xmin      <= '0;
      xmax      <= '0;
      ymax      <= '0;
      x         <= '0;
      y         <= '0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      count     <= '0;
    end else begin
      case (estado)
        ST_IDLE: if (start) begin
          vx    <= {p3x, p2x, p1x};
          vy    <= {p3y, p2y, p1y};
          count <= '0;
        end
        ST_SETUP: begin
          xmin <= bx_min;
          xmax <= bx_max;
          ymax <= by_max;
          x    <= bx_min;
          y    <= by_min;
          neg  <= area_neg;
        end
        ST_SCAN: if (adv) begin
          if (inside_ok) begin
            out_x     <= x;
            out_y     <= y;
            out_valid <= 1'b1;
            count     <= count + CNT_W'(1);
          end else begin
            out_valid <= 1'b0;
          end
          // Counters wrap to xmin / hold at ymax so box edges at 0 or
          // full-scale never overflow.
          if (x == xmax) begin
            x <= xmin;
            if (y != ymax) y <= y + COORD_W'(1);
          end else begin
            x <= x + COORD_W'(1);
          end
        end
        ST_FLUSH: if (!out_valid || out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rasterizador_triangulo.sv
module tb_rasterizador_triangulo;
  localparam int W  = 12;
  localparam int CW = 2 * W + 1;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [W-1:0] p1x, p1y, p2x, p2y, p3x, p3y;

  int   checks = 0, failures = 0;
  int   tv[6];
  bit   full_rdy;
  event ev_issue;

  typedef struct { int x; int y; } pt_t;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference geometry, straight from the edge-function definition.
  function automatic longint ecross(input int ax, ay, bx, by, tx, ty);
    return longint'(tx - bx) * longint'(ay - by) - longint'(ax - bx) * longint'(ty - by);
  endfunction

  function automatic bit in_tri(input longint area, input int px, py, input bit inc);
    longint s, v[3];
    s    = (area > 0) ? 1 : -1;
    v[0] = ecross(tv[0], tv[1], tv[2], tv[3], px, py) * s;
    v[1] = ecross(tv[2], tv[3], tv[4], tv[5], px, py) * s;
    v[2] = ecross(tv[4], tv[5], tv[0], tv[1], px, py) * s;
    if (inc) return (v[0] >= 0) && (v[1] >= 0) && (v[2] >= 0);
    return (v[0] > 0) && (v[1] > 0) && (v[2] > 0);
  endfunction

  function automatic int min3(input int a, b, c);
    int m = a; if (b < m) m = b; if (c < m) m = c; return m;
  endfunction
  function automatic int max3(input int a, b, c);
    int m = a; if (b > m) m = b; if (c > m) m = c; return m;
  endfunction

  // cfg 0: inclusive, both windings; cfg 1: strict interior; cfg 2: positive winding only
  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam bit INC = (g != 1);
    localparam bit BW  = (g != 2);
    logic busy, ov, done;
    logic [W-1:0]  ox, oy;
    logic [CW-1:0] cnt;
    pt_t q[$];
    int  exp_cnt, exp_busy, bcyc, acc, sx, sy;
    bit  seen, st;

    rasterizador_triangulo #(.COORD_W(W), .INCL_EDGE(INC), .BOTH_WINDINGS(BW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
      .busy(busy), .out_valid(ov), .out_ready(out_ready),
      .out_x(ox), .out_y(oy), .done(done), .count(cnt)
    );

    // Scoreboard fill: expected stream for the triangle just issued.
    always @(ev_issue) begin
      longint area;
      int x0, x1, y0, y1;
      pt_t p;
      q.delete();
      exp_cnt = 0; bcyc = 0; seen = 0; acc = 0;
      area = ecross(tv[0], tv[1], tv[2], tv[3], tv[4], tv[5]);
      x0 = min3(tv[0], tv[2], tv[4]); x1 = max3(tv[0], tv[2], tv[4]);
      y0 = min3(tv[1], tv[3], tv[5]); y1 = max3(tv[1], tv[3], tv[5]);
      if (area == 0 || (area < 0 && !BW)) begin
        exp_busy = 1;
      end else begin
        exp_busy = 2 + (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int yy = y0; yy <= y1; yy++)
          for (int xx = x0; xx <= x1; xx++)
            if (in_tri(area, xx, yy, INC)) begin
              p.x = xx; p.y = yy;
              q.push_back(p);
              exp_cnt++;
            end
      end
    end

    // Monitor: pops on every handshake, checks stall stability and the done summary.
    always @(negedge clk) begin
      pt_t e;
      if (rst) begin
        st = 0;
      end else begin
        if (busy) bcyc++;
        if (st) chk(ov && ox == W'(sx) && oy == W'(sy), $sformatf("stall_hold_cfg%0d", g),
                    {ov, ox, oy}, {1'b1, W'(sx), W'(sy)});
        st = 0;
        if (ov) begin
          if (out_ready) begin
            acc++;
            if (q.size() == 0) chk(0, $sformatf("extra_point_cfg%0d", g), ox * 65536 + oy, -1);
            else begin
              e = q.pop_front();
              chk(ox == W'(e.x) && oy == W'(e.y), $sformatf("point_cfg%0d", g),
                  ox * 65536 + oy, e.x * 65536 + e.y);
            end
          end else begin
            st = 1; sx = int'(ox); sy = int'(oy);
          end
        end
        if (done) begin
          chk(cnt == CW'(exp_cnt), $sformatf("count_cfg%0d", g), cnt, exp_cnt);
          chk(q.size() == 0, $sformatf("missing_points_cfg%0d", g), q.size(), 0);
          if (full_rdy) chk(bcyc == exp_busy, $sformatf("busy_cycles_cfg%0d", g), bcyc, exp_busy);
          seen = 1;
        end
      end
    end
  end

  task automatic issue(input int ax, ay, bx, by, cx, cy, input bit rnd);
    @(posedge clk); #1;
    tv = '{ax, ay, bx, by, cx, cy};
    p1x = W'(ax); p1y = W'(ay); p2x = W'(bx); p2y = W'(by); p3x = W'(cx); p3y = W'(cy);
    full_rdy  = !rnd;
    out_ready = 1'b1;
    start     = 1'b1;
    -> ev_issue;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input bit noise);
    bit ok = 0;
    for (int c = 0; c < 6000; c++) begin
      if (cfg[0].seen && cfg[1].seen && cfg[2].seen) begin ok = 1; break; end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise && c == 30) begin
        // Ignored request: different vertices must not leak into the scan.
        p1x = W'($urandom_range(0, 4095)); p2y = W'($urandom_range(0, 4095));
        start = 1'b1;
      end else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk(ok, "done_timeout", ok, 1);
    out_ready = 1'b1;
  endtask

  task automatic run_tri(input int ax, ay, bx, by, cx, cy, input bit rnd, input bit noise);
    issue(ax, ay, bx, by, cx, cy, rnd);
    wait_done(rnd, noise);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; full_rdy = 1'b1;
    p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
    #1;
    chk({cfg[0].busy, cfg[0].ov, cfg[0].done} == 3'b0, "reset_ctrl", {cfg[0].busy, cfg[0].ov, cfg[0].done}, 0);
    chk(cfg[0].ox == 0 && cfg[0].oy == 0 && cfg[0].cnt == 0, "reset_data", cfg[0].cnt, 0);
    #22 rst = 1'b0;

    run_tri(10, 10, 30, 10, 20, 30, 0, 0);
    chk(cfg[0].cnt == 221, "main_incl_count", cfg[0].cnt, 221);
    chk(cfg[1].cnt == 181, "main_strict_count", cfg[1].cnt, 181);
    chk(cfg[2].cnt == 221, "main_ccwonly_count", cfg[2].cnt, 221);

    run_tri(10, 10, 20, 30, 30, 10, 0, 0);
    chk(cfg[0].cnt == 221, "reorder_count", cfg[0].cnt, 221);
    chk(cfg[2].cnt == 0, "reorder_single_winding", cfg[2].cnt, 0);

    run_tri(0, 0, 5, 5, 10, 10, 0, 0);
    chk(cfg[0].cnt == 0, "collinear_count", cfg[0].cnt, 0);
    run_tri(7, 7, 7, 7, 7, 7, 0, 0);

    run_tri(0, 0, 12, 0, 0, 9, 0, 0);
    run_tri(4095, 4095, 4083, 4095, 4095, 4084, 0, 0);
    run_tri(4095, 4084, 4083, 4095, 4095, 4095, 1, 0);

    run_tri(10, 10, 30, 10, 20, 30, 1, 0);
    chk(cfg[0].cnt == 221, "stall_main_count", cfg[0].cnt, 221);

    for (int n = 0; n < 8; n++) begin
      int bx0, by0;
      bx0 = $urandom_range(0, 4095 - 16);
      by0 = $urandom_range(0, 4095 - 16);
      run_tri(bx0 + $urandom_range(0, 15), by0 + $urandom_range(0, 15),
              bx0 + $urandom_range(0, 15), by0 + $urandom_range(0, 15),
              bx0 + $urandom_range(0, 15), by0 + $urandom_range(0, 15), n[0], 0);
    end

    // Reset in the middle of a scan, then a clean rerun with a stray start.
    issue(10, 10, 30, 10, 20, 30, 0);
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      if (cfg[0].acc >= 50) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk(ok, "reset_wait_timeout", cfg[0].acc, 50);
    #1 rst = 1'b1;
    #1;
    chk({cfg[0].busy, cfg[0].ov, cfg[0].done} == 3'b0, "midreset_ctrl", {cfg[0].busy, cfg[0].ov, cfg[0].done}, 0);
    chk(cfg[0].ox == 0 && cfg[0].oy == 0 && cfg[0].cnt == 0, "midreset_data", cfg[0].cnt, 0);
    chk({cfg[1].busy, cfg[1].ov, cfg[2].busy, cfg[2].ov} == 4'b0, "midreset_others",
        {cfg[1].busy, cfg[1].ov, cfg[2].busy, cfg[2].ov}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    run_tri(10, 10, 30, 10, 20, 30, 0, 1);
    chk(cfg[0].cnt == 221, "after_reset_count", cfg[0].cnt, 221);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
